// File: rtl/alu_pkg.sv
// Shared constants and types for the two-requester ALU arbiter.
// Op codes are listed for users; the arbiter passes them through untouched.
package alu_pkg;

  localparam int DW_DEF = 4;
  localparam int CW_DEF = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_ROL = 3'b110;
  localparam logic [2:0] OP_ROR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response bundle of the ALU arbiter.
// slave is the arbiter side, master the environment side.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
);

  logic          req0_valid;
  logic          req0_ready;
  logic [CW-1:0] req0_ctrl;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;
  logic          req0_cin;

  logic          req1_valid;
  logic          req1_ready;
  logic [CW-1:0] req1_ctrl;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;
  logic          req1_cin;

  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic          alu_cin;
  logic [CW-1:0] alu_ctrl;
  logic [DW-1:0] alu_out;
  logic          alu_cout;

  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [DW-1:0] rsp_out;
  logic          rsp_cout;

  logic          busy;

  modport slave (
    input  req0_valid, req0_ctrl, req0_a,
    input  req0_b, req0_cin,
    output req0_ready,
    input  req1_valid, req1_ctrl, req1_a,
    input  req1_b, req1_cin,
    output req1_ready,
    output alu_a, alu_b, alu_cin, alu_ctrl,
    input  alu_out, alu_cout,
    output rsp_valid, rsp_id, rsp_out,
    output rsp_cout,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_ctrl, req0_a,
    output req0_b, req0_cin,
    input  req0_ready,
    output req1_valid, req1_ctrl, req1_a,
    output req1_b, req1_cin,
    input  req1_ready,
    input  alu_a, alu_b, alu_cin, alu_ctrl,
    output alu_out, alu_cout,
    input  rsp_valid, rsp_id, rsp_out,
    input  rsp_cout,
    output rsp_ready,
    input  busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; last winner only moves on an accepted transfer.
// Reset leaves requester 1 as last winner so requester 0 takes the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant
);

  logic last;

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      (req == 2'b11): grant = ~last;
      (req == 2'b10): grant = 1'b1;
      default:        grant = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= grant;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: accept, execute
// for one cycle, then hold the tagged result until the consumer takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  state_t        state;
  state_t        state_nxt;
  logic          grant;
  logic          accept;
  logic          ready0;
  logic          ready1;

  logic [CW-1:0] op_ctrl;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          op_cin;
  logic          op_id;

  logic [DW-1:0] res_out;
  logic          res_cout;
  logic          rsp_valid_q;
  logic          busy_q;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({bus.req1_valid, bus.req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (state == IDLE) begin
      ready0 = bus.req0_valid && !grant;
      ready1 = bus.req1_valid && grant;
    end
    accept = ready0 || ready1;
  end

  // Status flags are registered from next state so they never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_ctrl     <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_cin      <= 1'b0;
      op_id       <= 1'b0;
      res_out     <= '0;
      res_cout    <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rsp_valid_q <= (state_nxt == RESP);
      busy_q      <= (state_nxt != IDLE);
      if (accept) begin
        op_id <= grant;
        if (grant) begin
          op_ctrl <= bus.req1_ctrl;
          op_a    <= bus.req1_a;
          op_b    <= bus.req1_b;
          op_cin  <= bus.req1_cin;
        end else begin
          op_ctrl <= bus.req0_ctrl;
          op_a    <= bus.req0_a;
          op_b    <= bus.req0_b;
          op_cin  <= bus.req0_cin;
        end
      end
      if (state == EXEC) begin
        res_out  <= bus.alu_out;
        res_cout <= bus.alu_cout;
      end
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.alu_a      = op_a;
  assign bus.alu_b      = op_b;
  assign bus.alu_cin    = op_cin;
  assign bus.alu_ctrl   = op_ctrl;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = op_id;
  assign bus.rsp_out    = res_out;
  assign bus.rsp_cout   = res_cout;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, corner sequences,
// and random traffic against a transaction-level model.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.DW(4), .CW(3)) bus ();

  alu_arbiter #(.DW(4), .CW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [4:0] alu_f(
    input logic [2:0] c, input logic [3:0] a,
    input logic [3:0] b, input logic ci);
    logic [4:0] r;
    case (c)
      3'd0: r = {1'b0, a} + {1'b0, b} + {4'b0, ci};
      3'd1: r = {1'b0, a} - {1'b0, b} - {4'b0, ci};
      3'd2: r = {1'b0, a | b};
      3'd3: r = {1'b0, a & b};
      3'd4: r = {a, ci};
      3'd5: r = {a[0], ci, a[3:1]};
      3'd6: r = {a[3], a[2:0], a[3]};
      default: r = {a[0], a[0], a[3:1]};
    endcase
    return r;
  endfunction

  always_comb begin
    {bus.alu_cout, bus.alu_out} =
      alu_f(bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.alu_cin);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input bit id, input bit v,
    input logic [2:0] c, input logic [3:0] a,
    input logic [3:0] b, input logic ci);
    if (id) begin
      bus.req1_valid = v; bus.req1_ctrl = c;
      bus.req1_a = a; bus.req1_b = b; bus.req1_cin = ci;
    end else begin
      bus.req0_valid = v; bus.req0_ctrl = c;
      bus.req0_a = a; bus.req0_b = b; bus.req0_cin = ci;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_id", int'(bus.rsp_id), 0);
    chk("rst_rsp_out", int'(bus.rsp_out), 0);
    chk("rst_rsp_cout", int'(bus.rsp_cout), 0);
    chk("rst_alu_a", int'(bus.alu_a), 0);
    chk("rst_alu_b", int'(bus.alu_b), 0);
    chk("rst_alu_cin", int'(bus.alu_cin), 0);
    chk("rst_alu_ctrl", int'(bus.alu_ctrl), 0);
    chk("rst_busy", int'(bus.busy), 0);
  endtask

  typedef struct {
    bit         id;
    logic [2:0] c;
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] eo;
    logic       ec;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{0, 3'd0, 4'h9, 4'h8, 1'b0, 4'h1, 1'b1};
    tbl[1] = '{1, 3'd1, 4'h3, 4'h5, 1'b0, 4'hE, 1'b1};
    tbl[2] = '{0, 3'd3, 4'hF, 4'h3, 1'b0, 4'h3, 1'b0};
    tbl[3] = '{1, 3'd2, 4'h5, 4'hA, 1'b0, 4'hF, 1'b0};
    tbl[4] = '{0, 3'd4, 4'h9, 4'h0, 1'b1, 4'h3, 1'b1};
    tbl[5] = '{1, 3'd5, 4'h4, 4'h0, 1'b1, 4'hA, 1'b0};
    tbl[6] = '{0, 3'd6, 4'h9, 4'h0, 1'b0, 4'h3, 1'b1};
    tbl[7] = '{1, 3'd7, 4'h6, 4'h0, 1'b0, 4'h3, 1'b0};
    tbl[8] = '{0, 3'd1, 4'h7, 4'h2, 1'b1, 4'h4, 1'b0};

    do_reset();
    #1 chk_reset_vals();

    // single-requester ops from the table
    foreach (tbl[i]) begin
      @(negedge clk);
      set_req(tbl[i].id, 1, tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].ci);
      bus.rsp_ready = 1'b1;
      #1;
      chk("tbl_ready", int'(tbl[i].id ? bus.req1_ready : bus.req0_ready), 1);
      chk("tbl_other_ready", int'(tbl[i].id ? bus.req0_ready : bus.req1_ready), 0);
      @(negedge clk);
      set_req(tbl[i].id, 0, 0, 0, 0, 0);
      #1;
      chk("tbl_exec_busy", int'(bus.busy), 1);
      chk("tbl_exec_ctrl", int'(bus.alu_ctrl), int'(tbl[i].c));
      chk("tbl_exec_a", int'(bus.alu_a), int'(tbl[i].a));
      chk("tbl_exec_rv", int'(bus.rsp_valid), 0);
      @(negedge clk);
      #1;
      chk("tbl_rsp_valid", int'(bus.rsp_valid), 1);
      chk("tbl_rsp_id", int'(bus.rsp_id), int'(tbl[i].id));
      chk("tbl_rsp_out", int'(bus.rsp_out), int'(tbl[i].eo));
      chk("tbl_rsp_cout", int'(bus.rsp_cout), int'(tbl[i].ec));
      @(negedge clk);
      #1;
      chk("tbl_idle_rv", int'(bus.rsp_valid), 0);
      chk("tbl_idle_busy", int'(bus.busy), 0);
    end

    // strict alternation with both requesters held valid
    do_reset();
    set_req(0, 1, 3'd3, 4'hF, 4'h3, 1'b0);
    set_req(1, 1, 3'd2, 4'h5, 4'hA, 1'b0);
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      int w;
      w = 0;
      do begin
        @(negedge clk);
        #1;
        w++;
      end while (!bus.rsp_valid && w < 10);
      chk("alt_timeout", int'(bus.rsp_valid), 1);
      chk("alt_id", int'(bus.rsp_id), n % 2);
      chk("alt_out", int'(bus.rsp_out), (n % 2) ? 15 : 3);
    end
    @(negedge clk);
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    // response back-pressure for five cycles
    set_req(0, 1, 3'd0, 4'h9, 4'h8, 1'b0);
    bus.rsp_ready = 1'b0;
    #1 chk("bp_ready0", int'(bus.req0_ready), 1);
    @(negedge clk);
    set_req(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    set_req(0, 1, 3'd1, 4'h1, 4'h1, 1'b0);
    set_req(1, 1, 3'd1, 4'h2, 4'h1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rv", int'(bus.rsp_valid), 1);
      chk("bp_out", int'(bus.rsp_out), 1);
      chk("bp_cout", int'(bus.rsp_cout), 1);
      chk("bp_id", int'(bus.rsp_id), 0);
      chk("bp_r0", int'(bus.req0_ready), 0);
      chk("bp_r1", int'(bus.req1_ready), 0);
      chk("bp_busy", int'(bus.busy), 1);
      @(negedge clk);
    end
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_rel_rv", int'(bus.rsp_valid), 0);
    chk("bp_rel_busy", int'(bus.busy), 0);
    @(negedge clk);
    #1 chk("bp_rel_rv2", int'(bus.rsp_valid), 0);

    // reset pulse during EXEC of a req1 op
    @(negedge clk);
    set_req(1, 1, 3'd1, 4'h3, 4'h5, 1'b0);
    #1 chk("rx_ready1", int'(bus.req1_ready), 1);
    @(negedge clk);
    set_req(1, 0, 0, 0, 0, 0);
    #1 chk("rx_exec_ctrl", int'(bus.alu_ctrl), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1 chk_reset_vals();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("rx_no_rsp", int'(bus.rsp_valid), 0);
    end
    set_req(0, 1, 3'd0, 4'h1, 4'h1, 1'b0);
    set_req(1, 1, 3'd0, 4'h2, 4'h2, 1'b0);
    #1;
    chk("rx_tie_r0", int'(bus.req0_ready), 1);
    chk("rx_tie_r1", int'(bus.req1_ready), 0);

    // random traffic against a transaction-level model
    do_reset();
    begin
      int phase;
      bit last;
      bit g;
      bit v0, v1, er0, er1;
      logic [2:0] c0, c1;
      logic [3:0] a0, b0, a1, b1;
      logic ci0, ci1;
      bit e_id;
      logic [2:0] e_c;
      logic [4:0] e_r;
      phase = 0;
      last = 1'b1;
      e_id = 0;
      e_c = '0;
      e_r = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        @(negedge clk);
        v0 = ($urandom_range(0, 2) != 0);
        v1 = ($urandom_range(0, 2) != 0);
        c0 = 3'($urandom); a0 = 4'($urandom);
        b0 = 4'($urandom); ci0 = 1'($urandom);
        c1 = 3'($urandom); a1 = 4'($urandom);
        b1 = 4'($urandom); ci1 = 1'($urandom);
        set_req(0, v0, c0, a0, b0, ci0);
        set_req(1, v1, c1, a1, b1, ci1);
        bus.rsp_ready = ($urandom_range(0, 2) != 0);
        #1;
        g = (v0 && v1) ? !last : v1;
        er0 = (phase == 0) && v0 && !g;
        er1 = (phase == 0) && v1 && g;
        chk("rnd_r0", int'(bus.req0_ready), int'(er0));
        chk("rnd_r1", int'(bus.req1_ready), int'(er1));
        chk("rnd_busy", int'(bus.busy), int'(phase != 0));
        chk("rnd_rv", int'(bus.rsp_valid), int'(phase == 2));
        if (phase == 1) chk("rnd_ctrl", int'(bus.alu_ctrl), int'(e_c));
        if (phase == 2) begin
          chk("rnd_id", int'(bus.rsp_id), int'(e_id));
          chk("rnd_out", int'(bus.rsp_out), int'(e_r[3:0]));
          chk("rnd_cout", int'(bus.rsp_cout), int'(e_r[4]));
        end
        if (er0 || er1) begin
          e_id = g;
          e_c = g ? c1 : c0;
          e_r = g ? alu_f(c1, a1, b1, ci1) : alu_f(c0, a0, b0, ci0);
          last = g;
          phase = 1;
        end else if (phase == 1) begin
          phase = 2;
        end else if (phase == 2 && bus.rsp_ready) begin
          phase = 0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
